// File: rtl/pcs_tx_pkg.sv
// Shared definitions for the multi-lane TX PCS: scheduler states and common constants.
// Imported by the alignment-marker scheduler and the lane inserters.
package pcs_tx_pkg;

   typedef enum logic [1:0] {
      AM_IDLE,
      AM_MARK,
      AM_DATA
   } am_sched_e;

   localparam int          AM_GAP_STD = 16383;
   localparam logic [1:0]  SH_CTRL    = 2'b10;

endpackage

// File: rtl/am_tx_sched_if.sv
// Block handshake between the upstream pipe, the scheduler and the per-lane marker inserters.
// The scheduler uses the master modport; the environment driving it uses the slave modport.
interface am_tx_sched_if #(
   parameter int LANE_N = 4
);
   logic              ds_ready_i;
   logic              us_valid_i;
   logic              us_ready_o;
   logic [LANE_N-1:0] marker_v_o;
   logic              blk_v_o;

   modport master (
      input  ds_ready_i,
      input  us_valid_i,
      output us_ready_o,
      output marker_v_o,
      output blk_v_o
   );

   modport slave (
      output ds_ready_i,
      output us_valid_i,
      input  us_ready_o,
      input  marker_v_o,
      input  blk_v_o
   );
endinterface

// File: rtl/am_tx_sched.sv
// Alignment-marker scheduler: claims one downstream slot every AM_GAP data blocks and
// raises marker_v on all lanes for it, back-pressuring upstream during that slot.
module am_tx_sched
   import pcs_tx_pkg::*;
#(
   parameter int LANE_N = 4,
   parameter int AM_GAP = AM_GAP_STD,
   parameter int CNT_W  = 14
) (
   input  logic                clk,
   input  logic                nreset,
   input  logic                en_i,
   am_tx_sched_if.master       bus,
   output logic                underrun_o,
   output logic [CNT_W-1:0]    gap_cnt_o
);

   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(AM_GAP - 1);
   localparam logic [CNT_W-1:0] GAP_FULL = CNT_W'(AM_GAP);

   am_sched_e        state_q;
   logic             active_q;
   logic             mark_q;
   logic             underrun_q;
   logic [CNT_W-1:0] gap_q;
   logic             accept;

   assign accept = bus.ds_ready_i & bus.us_valid_i;

   // The marker slot ignores us_valid_i: the slot belongs to the scheduler, not upstream.
   assign bus.us_ready_o = active_q & ~mark_q & bus.ds_ready_i;
   assign bus.blk_v_o    = active_q & (mark_q ? bus.ds_ready_i : accept);
   assign bus.marker_v_o = {LANE_N{active_q & mark_q}};
   assign underrun_o     = underrun_q;
   assign gap_cnt_o      = gap_q;

   // NOTE: all state updates use <= so every branch reads the pre-edge values of the registers.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q    <= AM_IDLE;
         active_q   <= 1'b0;
         mark_q     <= 1'b0;
         underrun_q <= 1'b0;
         gap_q      <= '0;
      end else begin
         active_q <= 1'b1;
         case (state_q)
            AM_IDLE: begin
               gap_q <= '0;
               if (en_i) begin
                  state_q <= AM_MARK;
                  mark_q  <= 1'b1;
               end
            end
            AM_MARK: begin
               // A marker slot is never aborted; disabling only takes effect once it is sent.
               if (bus.ds_ready_i) begin
                  gap_q   <= '0;
                  mark_q  <= 1'b0;
                  state_q <= en_i ? AM_DATA : AM_IDLE;
               end
            end
            AM_DATA: begin
               if (!en_i) begin
                  state_q <= AM_IDLE;
                  gap_q   <= '0;
               end else begin
                  if (bus.ds_ready_i && !bus.us_valid_i) begin
                     underrun_q <= 1'b1;
                  end
                  if (accept) begin
                     if (gap_q == GAP_LAST) begin
                        state_q <= AM_MARK;
                        mark_q  <= 1'b1;
                        gap_q   <= GAP_FULL;
                     end else begin
                        gap_q <= gap_q + 1'b1;
                     end
                  end
               end
            end
            default: begin
               state_q <= AM_IDLE;
               mark_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_am_tx_sched.sv
// Self-checking bench: two schedulers (short gap and standard gap) share stimulus and are
// compared every cycle against a behavioural model of marker debt and block counting.
module tb_am_tx_sched;

   localparam int LANE_N = 4;
   localparam int CNT_W  = 14;
   localparam int GAP_A  = 4;
   localparam int GAP_B  = 16383;

   logic clk = 1'b0;
   logic nreset = 1'b0;
   logic en = 1'b0;
   logic ds_ready = 1'b0;
   logic us_valid = 1'b0;

   always #5 clk = ~clk;

   am_tx_sched_if #(.LANE_N(LANE_N)) ifa ();
   am_tx_sched_if #(.LANE_N(LANE_N)) ifb ();

   assign ifa.ds_ready_i = ds_ready;
   assign ifa.us_valid_i = us_valid;
   assign ifb.ds_ready_i = ds_ready;
   assign ifb.us_valid_i = us_valid;

   logic             und_a, und_b;
   logic [CNT_W-1:0] gap_a, gap_b;

   am_tx_sched #(.LANE_N(LANE_N), .AM_GAP(GAP_A), .CNT_W(CNT_W)) dut_a (
      .clk        (clk),
      .nreset     (nreset),
      .en_i       (en),
      .bus        (ifa.master),
      .underrun_o (und_a),
      .gap_cnt_o  (gap_a)
   );

   am_tx_sched #(.LANE_N(LANE_N), .AM_GAP(GAP_B), .CNT_W(CNT_W)) dut_b (
      .clk        (clk),
      .nreset     (nreset),
      .en_i       (en),
      .bus        (ifb.master),
      .underrun_o (und_b),
      .gap_cnt_o  (gap_b)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: whether a marker is owed, whether data is streaming, blocks since last marker.
   int gapv [2] = '{GAP_A, GAP_B};
   bit m_act [2];
   bit m_owe [2];
   bit m_str [2];
   bit m_und [2];
   int m_cnt [2];

   always @(posedge clk or negedge nreset) begin
      for (int k = 0; k < 2; k++) begin
         if (!nreset) begin
            m_act[k] = 1'b0;
            m_owe[k] = 1'b0;
            m_str[k] = 1'b0;
            m_und[k] = 1'b0;
            m_cnt[k] = 0;
         end else begin
            m_act[k] = 1'b1;
            if (m_owe[k]) begin
               if (ds_ready) begin
                  m_owe[k] = 1'b0;
                  m_str[k] = en;
                  m_cnt[k] = 0;
               end
            end else if (m_str[k]) begin
               if (!en) begin
                  m_str[k] = 1'b0;
                  m_cnt[k] = 0;
               end else begin
                  if (ds_ready && !us_valid) m_und[k] = 1'b1;
                  if (ds_ready && us_valid) begin
                     m_cnt[k]++;
                     if (m_cnt[k] == gapv[k]) begin
                        m_str[k] = 1'b0;
                        m_owe[k] = 1'b1;
                     end
                  end
               end
            end else if (en) begin
               m_owe[k] = 1'b1;
            end
         end
      end
   end

   // Independent spacing bookkeeping: data blocks observed between consecutive markers.
   int  data_since [2];
   bit  have_prev  [2];
   bit  clean      [2];
   int  peak       [2];

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         logic [LANE_N-1:0] mk;
         logic              ur, bv, un;
         logic [CNT_W-1:0]  gc;
         logic [LANE_N-1:0] e_mk;
         logic              e_ur, e_bv;
         string             tag;
         tag = (k == 0) ? "a" : "b";
         mk  = (k == 0) ? ifa.marker_v_o : ifb.marker_v_o;
         ur  = (k == 0) ? ifa.us_ready_o : ifb.us_ready_o;
         bv  = (k == 0) ? ifa.blk_v_o    : ifb.blk_v_o;
         un  = (k == 0) ? und_a : und_b;
         gc  = (k == 0) ? gap_a : gap_b;
         e_mk = (m_act[k] && m_owe[k]) ? {LANE_N{1'b1}} : '0;
         e_ur = m_act[k] && !m_owe[k] && ds_ready;
         e_bv = m_act[k] && (m_owe[k] ? ds_ready : (ds_ready && us_valid));
         check($sformatf("%s marker_v", tag), 32'(mk), 32'(e_mk));
         check($sformatf("%s us_ready", tag), 32'(ur), 32'(e_ur));
         check($sformatf("%s blk_v", tag), 32'(bv), 32'(e_bv));
         check($sformatf("%s underrun", tag), 32'(un), 32'(m_und[k]));
         check($sformatf("%s gap_cnt", tag), 32'(gc), 32'(m_cnt[k]));

         if (!nreset) begin
            have_prev[k]  = 1'b0;
            data_since[k] = 0;
            peak[k]       = 0;
         end else begin
            if (int'(gc) > peak[k]) peak[k] = int'(gc);
            if (bv && mk[0]) begin
               if (have_prev[k] && clean[k])
                  check($sformatf("%s marker spacing", tag), 32'(data_since[k]), 32'(gapv[k]));
               have_prev[k]  = 1'b1;
               clean[k]      = 1'b1;
               data_since[k] = 0;
            end else if (bv) begin
               data_since[k]++;
            end
            if (!en) clean[k] = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   int marks;
   int budget;

   initial begin
      // Scenario: continuous traffic from reset release.
      en = 1'b1; ds_ready = 1'b1; us_valid = 1'b1;
      #12 nreset = 1'b1;
      tick();
      check("t1 first marker", 32'(ifa.marker_v_o), 32'h0000_000f);
      check("t1 marker us_ready", 32'(ifa.us_ready_o), 32'd0);
      check("t1 marker blk_v", 32'(ifa.blk_v_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t1 data us_ready", 32'(ifa.us_ready_o), 32'd1);
         check("t1 data no marker", 32'(ifa.marker_v_o), 32'd0);
         check("t1 data gap_cnt", 32'(gap_a), 32'(i));
      end
      tick();
      check("t1 second marker", 32'(ifa.marker_v_o), 32'h0000_000f);
      check("t1 gap peak in mark", 32'(gap_a), 32'd4);

      // Downstream stall during the marker slot.
      ds_ready = 1'b0;
      #1 check("t2 stall blk_v", 32'(ifa.blk_v_o), 32'd0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("t2 marker held", 32'(ifa.marker_v_o), 32'h0000_000f);
         check("t2 stall us_ready", 32'(ifa.us_ready_o), 32'd0);
      end
      tick();
      ds_ready = 1'b1;
      #1 check("t2 marker sent", 32'(ifa.blk_v_o), 32'd1);

      // Upstream underrun after two data blocks.
      tick();
      tick();
      tick();
      us_valid = 1'b0;
      #1 check("t3 underrun no blk", 32'(ifa.blk_v_o), 32'd0);
      tick();
      us_valid = 1'b1;
      check("t3 underrun sticky", 32'(und_a), 32'd1);
      check("t3 gap held", 32'(gap_a), 32'd2);
      tick();
      tick();
      check("t3 marker after 4", 32'(ifa.marker_v_o), 32'h0000_000f);
      check("t3 underrun still", 32'(und_a), 32'd1);

      // Disabled after reset, then enabled; then disable while a marker is stalled.
      nreset = 1'b0;
      en = 1'b0;
      @(negedge clk);
      #2 nreset = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         ds_ready = 1'($urandom_range(0, 1));
         #1 check("t4 passthrough ready", 32'(ifa.us_ready_o), 32'(ds_ready));
         check("t4 no marker", 32'(ifa.marker_v_o), 32'd0);
         tick();
      end
      ds_ready = 1'b0;
      en = 1'b1;
      tick();
      check("t4 marker after enable", 32'(ifa.marker_v_o), 32'h0000_000f);
      en = 1'b0;
      tick();
      check("t5 marker held disabled", 32'(ifa.marker_v_o), 32'h0000_000f);
      ds_ready = 1'b1;
      #1 check("t5 marker taken", 32'(ifa.blk_v_o), 32'd1);
      marks = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ifa.marker_v_o != 0) marks++;
      end
      check("t5 idle marker count", 32'(marks), 32'd0);

      // Randomized traffic with occasional enable toggles.
      en = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         ds_ready = ($urandom_range(0, 9) < 7);
         us_valid = ($urandom_range(0, 9) < 9);
         if ($urandom_range(0, 63) == 0) en = ~en;
         tick();
      end

      // Standard gap: continuous traffic over two full intervals.
      en = 1'b1; ds_ready = 1'b1; us_valid = 1'b1;
      nreset = 1'b0;
      @(negedge clk);
      #2 nreset = 1'b1;
      marks = 0;
      for (int i = 0; i < 33000; i++) begin
         tick();
         if (ifb.marker_v_o != 0) marks++;
      end
      check("t6 std marker count", 32'(marks), 32'd3);
      check("t6 std gap peak", 32'(peak[1]), 32'(GAP_B));

      // Asynchronous reset in the middle of a marker slot.
      budget = 20;
      while (ifa.marker_v_o == 0 && budget > 0) begin
         tick();
         budget--;
      end
      check("t6 marker seen before reset", 32'(ifa.marker_v_o != 0), 32'd1);
      #1 nreset = 1'b0;
      #1;
      check("t6 reset marker_v", 32'(ifa.marker_v_o | ifb.marker_v_o), 32'd0);
      check("t6 reset us_ready", 32'(ifa.us_ready_o | ifb.us_ready_o), 32'd0);
      check("t6 reset blk_v", 32'(ifa.blk_v_o | ifb.blk_v_o), 32'd0);
      check("t6 reset gap_cnt", 32'(gap_a | gap_b), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
